// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller: queued requests in a pending bitmask, SCAN service order,
// timed floor legs, timed door dwell and an overweight hold with the door open.
//
// state | meaning
// IDLE  | no work; direction=00, door closed
// MOVE  | travelling; timer counts the current one-floor leg
// DOOR  | door open at cur_floor; timer counts the dwell
// HOLD  | door open, overweight; departure held until over_weight clears
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int WEIGHT_W      = 11,
    parameter int MAX_WEIGHT    = 1000,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [WEIGHT_W-1:0]   weight,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [1:0]            direction,
    output logic                  door_open,
    output logic                  complete,
    output logic                  over_weight,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]    TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0]    DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]    NUM_F       = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [WEIGHT_W-1:0] MAX_W       = WEIGHT_W'(MAX_WEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR,
        ST_HOLD
    } state_t;

    state_t                  state;
    logic [TMR_W-1:0]        timer;

    logic                    req_in_range;
    logic                    door_req;
    logic [NUM_FLOORS-1:0]   req_mask;
    logic [NUM_FLOORS-1:0]   queue_mask;
    logic [NUM_FLOORS-1:0]   pend_with_req;
    logic [NUM_FLOORS-1:0]   cur_mask;
    logic [NUM_FLOORS-1:0]   step_mask;
    logic [NUM_FLOORS-1:0]   above_mask;
    logic [NUM_FLOORS-1:0]   below_mask;
    logic                    has_above;
    logic                    has_below;
    logic                    here_pending;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    arrive_hit;
    logic [1:0]              go_dir;

    assign req_in_range = req_valid && ({1'b0, req_floor} < NUM_F);
    assign door_req     = req_in_range && (req_floor == cur_floor);

    always_comb begin
        req_mask = '0;
        if (req_in_range) begin
            req_mask[req_floor] = 1'b1;
        end
    end

    // With the door open at cur_floor, a request for that floor is served by the open door.
    assign queue_mask    = ((state == ST_DOOR || state == ST_HOLD) && door_req) ? '0 : req_mask;
    assign pend_with_req = pending | queue_mask;

    always_comb begin
        cur_mask = '0;
        cur_mask[cur_floor] = 1'b1;
    end

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = pending[i] && (i > int'(cur_floor));
            below_mask[i] = pending[i] && (i < int'(cur_floor));
        end
    end

    assign has_above    = |above_mask;
    assign has_below    = |below_mask;
    assign here_pending = |(pending & cur_mask);

    always_comb begin
        step_floor = cur_floor;
        if (direction == DIR_UP && cur_floor != TOP_FLOOR) begin
            step_floor = cur_floor + 1'b1;
        end else if (direction == DIR_DN && cur_floor != '0) begin
            step_floor = cur_floor - 1'b1;
        end
    end

    always_comb begin
        step_mask = '0;
        step_mask[step_floor] = 1'b1;
    end

    // A request landing on the arrival edge for the arrival floor counts as served.
    assign arrive_hit = |(pend_with_req & step_mask);

    // SCAN decision: keep going while work lies ahead, else reverse, else idle.
    // An idle direction is treated as up, which matches the IDLE departure rule.
    always_comb begin
        go_dir = DIR_IDLE;
        if (direction == DIR_DN) begin
            if (has_below) begin
                go_dir = DIR_DN;
            end else if (has_above) begin
                go_dir = DIR_UP;
            end
        end else begin
            if (has_above) begin
                go_dir = DIR_UP;
            end else if (has_below) begin
                go_dir = DIR_DN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cur_floor   <= '0;
            direction   <= DIR_IDLE;
            door_open   <= 1'b0;
            complete    <= 1'b0;
            over_weight <= 1'b0;
            pending     <= '0;
        end else begin
            over_weight <= (weight > MAX_W);
            complete    <= 1'b0;
            pending     <= pend_with_req;

            case (state)
                ST_IDLE: begin
                    direction <= DIR_IDLE;
                    if (here_pending) begin
                        state     <= ST_DOOR;
                        door_open <= 1'b1;
                        timer     <= DOOR_LOAD;
                        pending   <= pend_with_req & ~cur_mask;
                    end else if (has_above || has_below) begin
                        state     <= ST_MOVE;
                        direction <= has_above ? DIR_UP : DIR_DN;
                        timer     <= TRAVEL_LOAD;
                    end
                end

                ST_MOVE: begin
                    if (timer == '0) begin
                        cur_floor <= step_floor;
                        if (arrive_hit) begin
                            state     <= ST_DOOR;
                            door_open <= 1'b1;
                            complete  <= 1'b1;
                            timer     <= DOOR_LOAD;
                            pending   <= pend_with_req & ~step_mask;
                        end else begin
                            timer <= TRAVEL_LOAD;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_DOOR: begin
                    if (door_req) begin
                        timer <= DOOR_LOAD;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (over_weight) begin
                        state <= ST_HOLD;
                    end else begin
                        door_open <= 1'b0;
                        direction <= go_dir;
                        timer     <= TRAVEL_LOAD;
                        state     <= (go_dir == DIR_IDLE) ? ST_IDLE : ST_MOVE;
                    end
                end

                ST_HOLD: begin
                    if (!over_weight) begin
                        door_open <= 1'b0;
                        direction <= go_dir;
                        timer     <= TRAVEL_LOAD;
                        state     <= (go_dir == DIR_IDLE) ? ST_IDLE : ST_MOVE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scenario bench for elevator_scan_ctrl against a cycle-stepped behavioural model
// (elapsed-time counters, signed direction, per-floor request flags).
module tb_elevator_scan_ctrl;

    localparam int N    = 8;
    localparam int FW   = 3;
    localparam int WW   = 11;
    localparam int MAXW = 1000;
    localparam int TC   = 4;
    localparam int DC   = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic [WW-1:0] weight;
    logic [FW-1:0] cur_floor;
    logic [1:0]    direction;
    logic          door_open;
    logic          complete;
    logic          over_weight;
    logic [N-1:0]  pending;

    // five-floor instance, so that out-of-range floor codes exist on a 3-bit port
    logic          req_valid_s;
    logic [2:0]    req_floor_s;
    logic [2:0]    s_cur_floor;
    logic [1:0]    s_direction;
    logic          s_door_open;
    logic          s_complete;
    logic          s_over_weight;
    logic [4:0]    s_pending;

    elevator_scan_ctrl #(
        .NUM_FLOORS(N), .FLOOR_W(FW), .WEIGHT_W(WW), .MAX_WEIGHT(MAXW),
        .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .weight(weight), .cur_floor(cur_floor), .direction(direction),
        .door_open(door_open), .complete(complete), .over_weight(over_weight),
        .pending(pending)
    );

    elevator_scan_ctrl #(
        .NUM_FLOORS(5), .FLOOR_W(3), .WEIGHT_W(WW), .MAX_WEIGHT(MAXW),
        .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut_small (
        .clk(clk), .reset(reset), .req_valid(req_valid_s), .req_floor(req_floor_s),
        .weight(weight), .cur_floor(s_cur_floor), .direction(s_direction),
        .door_open(s_door_open), .complete(s_complete), .over_weight(s_over_weight),
        .pending(s_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] obs;
    logic [15:0] exp_v;

    // behavioural model
    localparam int PH_IDLE   = 0;
    localparam int PH_TRAVEL = 1;
    localparam int PH_DOOR   = 2;
    localparam int PH_HOLD   = 3;

    int m_cur, m_dir, m_elapsed, m_phase;
    bit m_door, m_complete, m_ow;
    bit m_pend[N];

    function automatic logic [15:0] model_vec();
        logic [N-1:0] p;
        logic [1:0]   d;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        d = (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00;
        return {FW'(m_cur), d, m_door, m_complete, m_ow, p};
    endfunction

    task automatic model_decide(input bit above, input bit below);
        bit ahead, behind;
        ahead  = (m_dir < 0) ? below : above;
        behind = (m_dir < 0) ? above : below;
        m_door = 1'b0;
        m_elapsed = 0;
        if (ahead) begin
            if (m_dir == 0) m_dir = 1;
            m_phase = PH_TRAVEL;
        end else if (behind) begin
            m_dir = (m_dir < 0) ? 1 : -1;
            m_phase = PH_TRAVEL;
        end else begin
            m_dir = 0;
            m_phase = PH_IDLE;
        end
    endtask

    task automatic model_step();
        bit req_ok, here, above, below, ow0;
        if (reset) begin
            m_cur = 0; m_dir = 0; m_elapsed = 0; m_phase = PH_IDLE;
            m_door = 0; m_complete = 0; m_ow = 0;
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            return;
        end
        req_ok = req_valid && (int'(req_floor) < N);
        ow0 = m_ow;
        here = m_pend[m_cur];
        above = 0;
        below = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && i > m_cur) above = 1;
            if (m_pend[i] && i < m_cur) below = 1;
        end
        m_complete = 0;
        if (req_ok && !((m_phase == PH_DOOR || m_phase == PH_HOLD) && int'(req_floor) == m_cur))
            m_pend[req_floor] = 1;
        case (m_phase)
            PH_IDLE: begin
                if (here) begin
                    m_phase = PH_DOOR; m_door = 1; m_elapsed = 0; m_pend[m_cur] = 0;
                end else if (above || below) begin
                    m_phase = PH_TRAVEL; m_dir = above ? 1 : -1; m_elapsed = 0;
                end
            end
            PH_TRAVEL: begin
                m_elapsed++;
                if (m_elapsed == TC) begin
                    m_cur += m_dir;
                    m_elapsed = 0;
                    if (m_pend[m_cur]) begin
                        m_pend[m_cur] = 0; m_complete = 1; m_door = 1; m_phase = PH_DOOR;
                    end
                end
            end
            PH_DOOR: begin
                if (req_ok && int'(req_floor) == m_cur) begin
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == DC) begin
                        if (ow0) m_phase = PH_HOLD;
                        else model_decide(above, below);
                    end
                end
            end
            default: begin
                if (!ow0) model_decide(above, below);
            end
        endcase
        m_ow = (int'(weight) > MAXW);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; weight = '0;
        tick(); tick();
        obs = {cur_floor, direction, door_open, complete, over_weight, pending};
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++; $display("FAIL reset_state: got %h expected 0000", obs);
        end
        reset = 1'b0;
        tick();
        obs = {cur_floor, direction, door_open, complete, over_weight, pending};
        exp_v = model_vec();
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_weight_limit();
        logic [WW-1:0] wv[3];
        bit            ov[3];
        wv[0] = 11'd1000; ov[0] = 1'b0;
        wv[1] = 11'd1001; ov[1] = 1'b1;
        wv[2] = 11'd0;    ov[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            weight = wv[i];
            tick();
            n_cmp++;
            if (over_weight !== ov[i]) begin
                n_bad++; $display("FAIL weight_limit w=%0d: got %b expected %b", wv[i], over_weight, ov[i]);
            end
        end
    endtask

    task automatic test_single_trip();
        req_valid = 1'b1; req_floor = 3'd3;
        for (int k = 1; k <= 22; k++) begin
            tick();
            req_valid = 1'b0;
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL single_trip k=%0d: got %h expected %h", k, obs, exp_v);
            end
            if (k == 1) begin
                n_cmp++;
                if (pending !== 8'h08) begin
                    n_bad++; $display("FAIL single_trip_queue: got %h expected 08", pending);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (direction !== 2'b01 || door_open !== 1'b0) begin
                    n_bad++; $display("FAIL single_trip_depart: got dir %b door %b expected 01 0", direction, door_open);
                end
            end
            if (k == 14) begin
                n_cmp++;
                if ({cur_floor, complete, door_open} !== {3'd3, 1'b1, 1'b1}) begin
                    n_bad++; $display("FAIL single_trip_arrive: got floor %0d cpl %b door %b expected 3 1 1", cur_floor, complete, door_open);
                end
            end
            if (k == 19) begin
                n_cmp++;
                if (door_open !== 1'b1) begin
                    n_bad++; $display("FAIL single_trip_dwell: got door %b expected 1", door_open);
                end
            end
            if (k == 20) begin
                n_cmp++;
                if ({door_open, direction, pending} !== 11'd0) begin
                    n_bad++; $display("FAIL single_trip_close: got door %b dir %b pend %h expected 0 00 00", door_open, direction, pending);
                end
            end
        end
    endtask

    task automatic test_scan_order();
        int served[$];
        int reqs[3];
        reqs[0] = 5; reqs[1] = 0; reqs[2] = 6;
        req_valid = 1'b1; req_floor = 3'd2;
        for (int k = 0; k < 30; k++) begin
            tick();
            req_valid = 1'b0;
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL scan_setup k=%0d: got %h expected %h", k, obs, exp_v);
            end
        end
        for (int k = 0; k < 103; k++) begin
            if (k < 3) begin
                req_valid = 1'b1; req_floor = FW'(reqs[k]);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (complete === 1'b1) served.push_back(int'(cur_floor));
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL scan_run k=%0d: got %h expected %h", k, obs, exp_v);
            end
        end
        n_cmp++;
        if (served.size() != 3) begin
            n_bad++; $display("FAIL scan_count: got %0d pulses expected 3", served.size());
        end else if (served[0] != 5 || served[1] != 6 || served[2] != 0) begin
            n_bad++; $display("FAIL scan_order: got %0d,%0d,%0d expected 5,6,0", served[0], served[1], served[2]);
        end
        n_cmp++;
        if (pending !== 8'h00) begin
            n_bad++; $display("FAIL scan_drain: got %h expected 00", pending);
        end
    endtask

    task automatic test_overweight();
        bit seen;
        seen = 1'b0;
        weight = 11'd1024;
        req_valid = 1'b1; req_floor = 3'd1;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            req_valid = (k == 0);
            req_floor = 3'd4;
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL ow_approach k=%0d: got %h expected %h", k, obs, exp_v);
            end
            if (door_open === 1'b1) seen = 1'b1;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL ow_arrive: got no door opening expected one within 30 cycles");
        end
        for (int k = 0; k < DC + 20; k++) begin
            tick();
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL ow_hold k=%0d: got %h expected %h", k, obs, exp_v);
            end
            n_cmp++;
            if ({cur_floor, door_open} !== {3'd1, 1'b1}) begin
                n_bad++; $display("FAIL ow_stationary k=%0d: got floor %0d door %b expected 1 1", k, cur_floor, door_open);
            end
        end
        weight = 11'd800;
        tick();
        n_cmp++;
        if ({over_weight, door_open} !== 2'b01) begin
            n_bad++; $display("FAIL ow_clear: got ow %b door %b expected 0 1", over_weight, door_open);
        end
        tick();
        n_cmp++;
        if ({door_open, direction} !== 3'b001) begin
            n_bad++; $display("FAIL ow_depart: got door %b dir %b expected 0 01", door_open, direction);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL ow_resume k=%0d: got %h expected %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_door_reload();
        bit seen;
        int open_cnt;
        int tgt;
        seen = 1'b0;
        open_cnt = 0;
        tgt = (m_cur == N - 1) ? m_cur - 1 : m_cur + 1;
        req_valid = 1'b1; req_floor = FW'(tgt);
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            req_valid = 1'b0;
            if (door_open === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL reload_arrive: got no door opening expected one within 30 cycles");
        end
        tick(); tick();
        req_valid = 1'b1; req_floor = FW'(tgt);
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (pending !== 8'h00 || door_open !== 1'b1) begin
            n_bad++; $display("FAIL reload_not_queued: got pend %h door %b expected 00 1", pending, door_open);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (door_open === 1'b1) open_cnt++;
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL reload_run k=%0d: got %h expected %h", k, obs, exp_v);
            end
        end
        n_cmp++;
        if (open_cnt != DC - 1) begin
            n_bad++; $display("FAIL reload_dwell: got %0d open cycles expected %0d", open_cnt, DC - 1);
        end
    endtask

    task automatic test_range();
        logic [2:0] bad_f[3];
        bad_f[0] = 3'd5; bad_f[1] = 3'd6; bad_f[2] = 3'd7;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid_s = 1'b1; req_floor_s = bad_f[i];
            tick();
            n_cmp++;
            if (s_pending !== 5'b00000) begin
                n_bad++; $display("FAIL range_ignore f=%0d: got %b expected 00000", bad_f[i], s_pending);
            end
        end
        req_floor_s = 3'd4;
        tick();
        req_valid_s = 1'b0;
        n_cmp++;
        if (s_pending !== 5'b10000) begin
            n_bad++; $display("FAIL range_top: got %b expected 10000", s_pending);
        end
    endtask

    task automatic test_reset_mid_move();
        bit seen;
        seen = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 1'b1; req_floor = 3'd7;
        for (int k = 0; k < 80 && !seen; k++) begin
            tick();
            req_valid = (k == 0);
            req_floor = 3'd2;
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL midreset_run k=%0d: got %h expected %h", k, obs, exp_v);
            end
            if (cur_floor === 3'd4) seen = 1'b1;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL midreset_reach: got floor %0d expected to reach 4 within 80 cycles", cur_floor);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs = {cur_floor, direction, door_open, complete, over_weight, pending};
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++; $display("FAIL midreset_clear: got %h expected 0000", obs);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            n_cmp++;
            if (obs !== 16'h0000) begin
                n_bad++; $display("FAIL midreset_lost k=%0d: got %h expected 0000", k, obs);
            end
        end
    endtask

    task automatic test_arrival_collision();
        bit fired;
        int cnt5;
        fired = 1'b0;
        cnt5 = 0;
        req_valid = 1'b1; req_floor = 3'd6;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                req_valid = 1'b0;
                if (!fired && m_phase == PH_TRAVEL && m_elapsed == TC - 1 && m_cur + m_dir == 5) begin
                    req_valid = 1'b1; req_floor = 3'd5; fired = 1'b1;
                    tick();
                    req_valid = 1'b0;
                    n_cmp++;
                    if ({cur_floor, complete, door_open, pending[5]} !== {3'd5, 1'b1, 1'b1, 1'b0}) begin
                        n_bad++; $display("FAIL collide_edge: got floor %0d cpl %b door %b p5 %b expected 5 1 1 0", cur_floor, complete, door_open, pending[5]);
                    end
                    if (complete === 1'b1 && cur_floor === 3'd5) cnt5++;
                    continue;
                end
            end
            tick();
            if (complete === 1'b1 && cur_floor === 3'd5) cnt5++;
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL collide_run k=%0d: got %h expected %h", k, obs, exp_v);
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (!fired || cnt5 != 1) begin
            n_bad++; $display("FAIL collide_pulses: got fired %b pulses %0d expected 1 1", fired, cnt5);
        end
    endtask

    task automatic test_random();
        bit heavy;
        heavy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 900; k++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_floor = FW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 39) == 0) heavy = !heavy;
            case ($urandom_range(0, 9))
                0: weight = 11'd1000;
                1: weight = 11'd1001;
                default: weight = heavy ? WW'($urandom_range(1001, 2047)) : WW'($urandom_range(0, 1000));
            endcase
            reset = ($urandom_range(0, 399) == 0);
            tick();
            obs = {cur_floor, direction, door_open, complete, over_weight, pending};
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL random k=%0d: got %h expected %h", k, obs, exp_v);
            end
        end
        reset = 1'b0;
        req_valid = 1'b0;
        weight = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;
        weight = '0;
        req_valid_s = 1'b0;
        req_floor_s = '0;
        #1;
        test_reset();
        test_weight_limit();
        test_single_trip();
        test_scan_order();
        test_overweight();
        test_door_reload();
        test_range();
        test_reset_mid_move();
        test_arrival_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
